// File: rtl/booth_seq_pkg.sv
// rtl/booth_seq_pkg.sv - shared widths and FSM state encoding for the booth sequencer
`timescale 1ns/1ps
package booth_seq_pkg;

    localparam int OP_W   = 4;
    localparam int PROD_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/booth_seq_fifo.sv
// rtl/booth_seq_fifo.sv - operand-pair FIFO, power-of-two depth with wrapping pointers
`timescale 1ns/1ps
module booth_seq_fifo
    import booth_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 2 * OP_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    // A push is judged against the current occupancy only, so a same-cycle pop never frees a slot early.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/booth_seq.sv
// rtl/booth_seq.sv - sequences queued operand pairs through an external fixed-latency booth multiplier
`timescale 1ns/1ps
module booth_seq
    import booth_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LAT   = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_x,
    input  logic [OP_W-1:0]   in_y,
    output logic [OP_W-1:0]   mul_x,
    output logic [OP_W-1:0]   mul_y,
    output logic              mul_start,
    input  logic [PROD_W-1:0] mul_p,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] out_p,
    output logic [OP_W-1:0]   out_x,
    output logic [OP_W-1:0]   out_y
);

    localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [OP_W-1:0]     op_x_q, op_x_d;
    logic [OP_W-1:0]     op_y_q, op_y_d;
    logic [PROD_W-1:0]   out_p_q, out_p_d;
    logic [OP_W-1:0]     out_x_q, out_x_d;
    logic [OP_W-1:0]     out_y_q, out_y_d;
    logic                out_valid_q, out_valid_d;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [2*OP_W-1:0]   fifo_dout;

    booth_seq_fifo #(
        .DEPTH (DEPTH),
        .W     (2 * OP_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (in_valid),
        .data_i  ({in_x, in_y}),
        .pop_i   (fifo_pop),
        .data_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign in_ready  = !fifo_full;
    assign mul_x     = op_x_q;
    assign mul_y     = op_y_q;
    assign out_valid = out_valid_q;
    assign out_p     = out_p_q;
    assign out_x     = out_x_q;
    assign out_y     = out_y_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_x_d      = op_x_q;
        op_y_d      = op_y_q;
        out_p_d     = out_p_q;
        out_x_d     = out_x_q;
        out_y_d     = out_y_q;
        out_valid_d = out_valid_q;
        fifo_pop    = 1'b0;
        mul_start   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop         = 1'b1;
                    {op_x_d, op_y_d} = fifo_dout;
                    state_d          = ST_START;
                end
            end
            ST_START: begin
                mul_start = 1'b1;
                cnt_d     = CNT_LOAD;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                // Counter reads 0 exactly in the cycle the multiplier's product is valid.
                if (cnt_q == 4'd0) begin
                    out_p_d     = mul_p;
                    out_x_d     = op_x_q;
                    out_y_d     = op_y_q;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            op_x_q      <= '0;
            op_y_q      <= '0;
            out_p_q     <= '0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_x_q      <= op_x_d;
            op_y_q      <= op_y_d;
            out_p_q     <= out_p_d;
            out_x_q     <= out_x_d;
            out_y_q     <= out_y_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_booth_seq.sv
// tb/tb_booth_seq.sv - random and directed self-checking bench for booth_seq with a latency-exact multiplier model
`timescale 1ns/1ps
module tb_booth_seq;

    localparam int LAT = 6;

    typedef struct {
        logic [3:0] x;
        logic [3:0] y;
    } pair_t;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_x, in_y;
    logic [3:0] mul_x, mul_y;
    logic       mul_start;
    logic [7:0] mul_p;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_p;
    logic [3:0] out_x, out_y;

    booth_seq #(.DEPTH(4), .LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
        .mul_x(mul_x), .mul_y(mul_y), .mul_start(mul_start), .mul_p(mul_p),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_p(out_p), .out_x(out_x), .out_y(out_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_prod(input logic [3:0] x, input logic [3:0] y);
        int a, b, p;
        a = $signed(x);
        b = $signed(y);
        p = a * b;
        return p[7:0];
    endfunction

    // Multiplier model: product is correct only in the LAT-th cycle after the start pulse.
    int         m_cnt = 0;
    logic [7:0] m_prod = 8'h00;
    always @(posedge clk) begin
        if (mul_start) begin
            m_prod <= ref_prod(mul_x, mul_y);
            m_cnt  <= 1;
        end else if (m_cnt != 0 && m_cnt < 100) begin
            m_cnt <= m_cnt + 1;
        end
    end
    assign mul_p = (m_cnt == LAT) ? m_prod : ~m_prod;

    pair_t      q[$];
    logic [7:0] acc_p[$];
    logic [3:0] acc_x[$], acc_y[$];
    bit         busy = 0, prev_hold = 0, prev_ov = 0;
    logic [15:0] prev_vals;
    int         start_cyc = 0, push_cyc = 0, n_starts = 0, n_ov_rise = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            busy = 0; prev_hold = 0; prev_ov = 0;
        end else begin
            if (mul_start) begin
                check_eq("start_overlap", 32'(busy), 32'd0);
                if (q.size() > 0) check_eq("mul_xy", {mul_x, mul_y}, {q[0].x, q[0].y});
                busy = 1; start_cyc = cyc; n_starts++;
            end
            if (out_valid && !prev_ov) begin
                check_eq("start_to_valid", 32'(cyc - start_cyc), 32'(LAT + 1));
                n_ov_rise++;
            end
            if (prev_hold) begin
                check_eq("hold_valid", 32'(out_valid), 32'd1);
                check_eq("hold_data", {out_p, out_x, out_y}, prev_vals);
            end
            if (out_valid && out_ready) begin
                if (q.size() > 0) begin
                    check_eq("out_p", out_p, ref_prod(q[0].x, q[0].y));
                    check_eq("out_xy", {out_x, out_y}, {q[0].x, q[0].y});
                    void'(q.pop_front());
                end else begin
                    check_eq("spurious_out", 32'(out_valid), 32'd0);
                end
                acc_p.push_back(out_p); acc_x.push_back(out_x); acc_y.push_back(out_y);
                busy = 0;
            end
            prev_hold = out_valid && !out_ready;
            prev_vals = {out_p, out_x, out_y};
            prev_ov   = out_valid;
            if (in_valid && in_ready) begin
                q.push_back('{x: in_x, y: in_y});
                push_cyc = cyc;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the transfer edge.
    task automatic push(input logic [3:0] x, input logic [3:0] y);
        int k = 0;
        in_valid = 1'b1; in_x = x; in_y = y;
        do begin
            @(negedge clk);
            k++;
        end while (!in_ready && k < 500);
        if (!in_ready) check_eq("push_timeout", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int k = 0;
        while ((q.size() != 0 || busy) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check_eq("drain_q", 32'(q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    bit stop_rdy;

    initial begin
        int base, s0, a, s, r0, o0;
        rst_n = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_mul_start", 32'(mul_start), 32'd0);
        check_eq("rst_outs", {out_p, out_x, out_y, mul_x, mul_y}, 32'd0);
        @(posedge clk); #1;

        // Single operation
        base = acc_p.size();
        push(4'b0011, 4'b0100);
        wait_drain();
        check_eq("single_push_to_start", 32'(start_cyc - push_cyc), 32'd2);
        check_eq("single_starts", 32'(n_starts), 32'd1);
        check_eq("single_p", acc_p[base], 32'h0C);
        check_eq("single_x", acc_x[base], 32'h3);
        check_eq("single_y", acc_y[base], 32'h4);

        // Signed corners
        base = acc_p.size();
        push(4'b1111, 4'b1111);
        push(4'b1000, 4'b1000);
        push(4'b0111, 4'b1000);
        wait_drain();
        check_eq("corner0", acc_p[base],     32'b00000001);
        check_eq("corner1", acc_p[base + 1], 32'b01000000);
        check_eq("corner2", acc_p[base + 2], 32'b11001000);

        // Full FIFO with one pair in flight
        out_ready = 1'b0;
        base = acc_p.size(); s0 = n_starts;
        for (int i = 0; i < 5; i++) push(4'(i + 2), 4'(13 - i));
        @(negedge clk);
        check_eq("full_in_ready", 32'(in_ready), 32'd0);
        repeat (6) @(negedge clk);
        check_eq("full_still", 32'(in_ready), 32'd0);
        check_eq("full_one_started", 32'(n_starts - s0), 32'd1);
        @(posedge clk); #1 out_ready = 1'b1;
        wait_drain();
        check_eq("full_results", 32'(acc_p.size() - base), 32'd5);

        // Backpressure in DONE
        out_ready = 1'b0;
        push(4'b0101, 4'b1101);
        push(4'b1010, 4'b0110);
        a = 0;
        while (!out_valid && a < 100) begin @(negedge clk); a++; end
        check_eq("bp_valid", 32'(out_valid), 32'd1);
        s0 = n_starts;
        repeat (20) @(negedge clk);
        check_eq("bp_no_start", 32'(n_starts), 32'(s0));
        @(posedge clk); #1 out_ready = 1'b1;
        a = -1; s = -1;
        for (int k = 0; k < 50 && s < 0; k++) begin
            @(negedge clk);
            if (a < 0 && out_valid && out_ready) a = cyc;
            else if (a >= 0 && mul_start) s = cyc;
        end
        check_eq("bp_restart_gap", 32'(s - a), 32'd2);
        wait_drain();

        // Reset while in WAIT with two pairs queued
        push(4'b0010, 4'b0011);
        push(4'b0110, 4'b0111);
        push(4'b1001, 4'b0001);
        a = 0;
        while (!mul_start && a < 50) begin @(negedge clk); a++; end
        check_eq("rw_started", 32'(mul_start), 32'd1);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        r0 = n_starts; o0 = n_ov_rise;
        @(negedge clk);
        check_eq("rw_in_ready", 32'(in_ready), 32'd1);
        check_eq("rw_out_valid", 32'(out_valid), 32'd0);
        repeat (20) @(negedge clk);
        check_eq("rw_no_start", 32'(n_starts), 32'(r0));
        check_eq("rw_no_valid", 32'(n_ov_rise), 32'(o0));
        @(posedge clk); #1;

        // Random stream with random backpressure
        base = acc_p.size();
        stop_rdy = 0;
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    push(4'($urandom), 4'($urandom));
                end
                wait_drain();
                stop_rdy = 1;
            end
            begin
                while (!stop_rdy) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        check_eq("rand_count", 32'(acc_p.size() - base), 32'd20);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/booth_seq.md
BOOTH_SEQ -- requirements
Module: booth_seq

Interface
REQ-001 Parameter DEPTH, default 4, depth of the operand FIFO (power of two, 2..16).
REQ-002 Parameter LAT, default 6, cycles from the mul_start pulse to a valid mul_p (range 1..15).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  upstream operand pair present.
REQ-006 in_ready  output  1  block accepts the operand pair this cycle.
REQ-007 in_x, in_y  input  4 each  two's-complement operands.
REQ-008 mul_x, mul_y  output  4 each  operands driven to the booth multiplier.
REQ-009 mul_start  output  1  one-cycle start pulse to the booth multiplier.
REQ-010 mul_p  input  8  booth multiplier product.
REQ-011 out_valid  output  1  result held for downstream.
REQ-012 out_ready  input  1  downstream accepts the result.
REQ-013 out_p  output  8  product; out_x, out_y  output  4 each  the operands that produced it.

Function
REQ-014 An input transfer occurs when in_valid && in_ready; the pair is pushed at the FIFO tail.
REQ-015 in_ready = !full; a push is refused when full, even if a pop occurs the same cycle.
REQ-016 FSM states: IDLE, START, WAIT, DONE.
REQ-017 IDLE: if the FIFO is non-empty, pop the head into the op registers and go to START; otherwise stay.
REQ-018 A push into an empty FIFO is poppable no earlier than the next cycle (minimum latency in_valid -> mul_start = 2 cycles).
REQ-019 START: mul_start=1 for exactly this cycle; load the wait counter with LAT-1; go to WAIT.
REQ-020 mul_x/mul_y equal the op registers and stay stable from START until the next pop.
REQ-021 WAIT: decrement the counter each cycle; when it reads 0, capture mul_p into out_p, op registers into out_x/out_y, set out_valid and go to DONE.
REQ-022 The total from the START cycle to the first out_valid cycle is LAT+1 cycles.
REQ-023 DONE: hold out_p/out_x/out_y/out_valid stable until out_valid && out_ready.
REQ-024 On acceptance from DONE: clear out_valid; go to IDLE.
REQ-025 Back-to-back throughput is one result per LAT+3 cycles; no overlap of multiplications.
REQ-026 The FIFO keeps accepting pushes in every state while not full.
REQ-027 FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH.
REQ-028 The occupancy counter is log2(DEPTH)+1 bits; full = (count==DEPTH); empty = (count==0).
REQ-029 out_p is passed through unmodified; the block performs no arithmetic on the product.

Reset
REQ-030 rst_n low asynchronously forces: FSM=IDLE, FIFO empty, counter 0, mul_start=0, out_valid=0.
REQ-031 Reset also zeroes out_p, out_x, out_y, mul_x and mul_y; in_ready=1 in the first cycle after release.
REQ-032 A reset asserted mid-operation (START/WAIT/DONE) discards the in-flight pair, the queued pairs and the held result; no partial result is ever presented.

Structure
REQ-033 A shared package holds the FSM state enum, the operand width (4) and the product width (8).
REQ-034 The operand FIFO is one sub-module, booth_seq_fifo (DEPTH, 8-bit entries {x,y}), with push/pop/full/empty.
REQ-035 The FSM, counter and output registers live in booth_seq.

Verification (bench instantiates booth_seq and the booth multiplier, LAT=6, free-running clk with 10 ns period)
REQ-036 Single op: push x=0011, y=0100 -> one mul_start pulse; out_p=00001100 with out_x=0011, out_y=0100, LAT+1 cycles after START.
REQ-037 Signed corners: push (1111,1111), (1000,1000), (0111,1000) -> out_p 00000001, 01000000, 11001000, in order.
REQ-038 Full FIFO: push 5 pairs with out_ready=0 -> in_ready=0 after 4 are queued (1 in flight); all 5 results emerge in order once out_ready=1.
REQ-039 Backpressure: hold out_ready=0 for 20 cycles in DONE -> out_p/out_valid stable, no new mul_start; on release, the next START follows 2 cycles later.
REQ-040 Reset in WAIT: assert rst_n=0 for 1 cycle during WAIT with 2 pairs queued -> out_valid never asserts for them; in_ready=1; FSM=IDLE.
REQ-041 Wrap-around: stream 20 random pairs with random out_ready -> every out_p matches x*y (signed) in order, and no mul_start is issued while in WAIT or DONE.
